// File: rtl/mac_pe_pipe.sv
// Systolic MAC processing element: registered multiply, accumulate, handshaked result register.
// Optional macro MAC_SAT_EN: saturating accumulation with sticky sat_flag (wraps when undefined).
module mac_pe_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en_in,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  last_in,
  output logic                  en_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  last_out,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic                  res_ovf,
  output logic                  sat_flag
);

  localparam int P_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_MSB = ACC_WIDTH - 1;

  logic [P_WIDTH-1:0]   prod_s;
  logic [P_WIDTH-1:0]   prod_u;
  logic [P_WIDTH-1:0]   p_q;
  logic                 p_vld;
  logic                 p_last;
  logic                 p_sgn;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 first;
  logic                 done_vld;
  logic [ACC_WIDTH-1:0] done_sum;

  // Operands are widened before the multiply so the full product is kept.
  assign prod_s = P_WIDTH'($signed(a_in)) * P_WIDTH'($signed(b_in));
  assign prod_u = P_WIDTH'(a_in) * P_WIDTH'(b_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out   <= 1'b0;
      b_out    <= '0;
      last_out <= 1'b0;
      p_vld    <= 1'b0;
      p_last   <= 1'b0;
      p_sgn    <= 1'b0;
      p_q      <= '0;
    end else if (clr) begin
      en_out   <= 1'b0;
      b_out    <= '0;
      last_out <= 1'b0;
      p_vld    <= 1'b0;
      p_last   <= 1'b0;
      p_sgn    <= 1'b0;
      p_q      <= '0;
    end else begin
      en_out   <= en_in;
      b_out    <= b_in;
      last_out <= last_in & en_in;
      p_vld    <= en_in;
      if (en_in) begin
        p_q    <= signed_mode ? prod_s : prod_u;
        p_last <= last_in;
        p_sgn  <= signed_mode;
      end
    end
  end

  always_comb begin
    ext  = p_sgn ? ACC_WIDTH'($signed(p_q)) : ACC_WIDTH'(p_q);
    base = first ? '0 : acc;
  end

`ifdef MAC_SAT_EN
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] s_min;
  logic                 sat_hit;

  // Signed terms clamp on two's-complement overflow, unsigned terms on carry-out.
  always_comb begin
    sum_wide       = {1'b0, base} + {1'b0, ext};
    s_min          = '0;
    s_min[ACC_MSB] = 1'b1;
    sum            = sum_wide[ACC_MSB:0];
    sat_hit        = 1'b0;
    if (p_sgn) begin
      if ((base[ACC_MSB] == ext[ACC_MSB]) && (sum[ACC_MSB] != base[ACC_MSB])) begin
        sat_hit = 1'b1;
        sum     = base[ACC_MSB] ? s_min : ~s_min;
      end
    end else if (sum_wide[ACC_WIDTH]) begin
      sat_hit = 1'b1;
      sum     = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (!clr && p_vld && sat_hit) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign sum      = base + ext;
  assign sat_flag = 1'b0;
`endif

  // Completed sums are staged in done_* so the result register sees them two edges after the last term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      first    <= 1'b1;
      done_vld <= 1'b0;
      done_sum <= '0;
    end else if (clr) begin
      acc      <= '0;
      first    <= 1'b1;
      done_vld <= 1'b0;
      done_sum <= '0;
    end else begin
      done_vld <= p_vld & p_last;
      if (p_vld) begin
        if (p_last) begin
          done_sum <= sum;
          acc      <= '0;
          first    <= 1'b1;
        end else begin
          acc      <= sum;
          first    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_out   <= '0;
      c_valid <= 1'b0;
      res_ovf <= 1'b0;
    end else if (clr) begin
      c_out   <= '0;
      c_valid <= 1'b0;
      res_ovf <= 1'b0;
    end else if (done_vld) begin
      if (!c_valid || c_ready) begin
        c_out   <= done_sum;
        c_valid <= 1'b1;
      end else begin
        res_ovf <= 1'b1;
      end
    end else if (c_valid && c_ready) begin
      c_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pe_pipe.sv
// Scoreboard bench for mac_pe_pipe: directed vectors push expected results, a monitor pops on handshake.
module tb_mac_pe_pipe;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        en_in, signed_mode, last_in, c_ready;
  logic [7:0]  a_in, b_in;
  logic        en_out, last_out, c_valid, res_ovf, sat_flag;
  logic [7:0]  b_out;
  logic [23:0] c_out;

  logic        en2, last2;
  logic [7:0]  a2, b2;
  logic        en_out2, last_out2, c_valid2, res_ovf2, sat_flag2;
  logic [7:0]  b_out2;
  logic [16:0] c_out2;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ovf;
  logic        exp_sat;

  always #5 clk = ~clk;

  mac_pe_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(24)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .en_in(en_in), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .last_in(last_in), .en_out(en_out), .b_out(b_out),
    .last_out(last_out), .c_out(c_out), .c_valid(c_valid), .c_ready(c_ready),
    .res_ovf(res_ovf), .sat_flag(sat_flag)
  );

  mac_pe_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(17)) u_ovf (
    .clk(clk), .rst(rst), .clr(clr), .en_in(en2), .signed_mode(1'b0),
    .a_in(a2), .b_in(b2), .last_in(last2), .en_out(en_out2), .b_out(b_out2),
    .last_out(last_out2), .c_out(c_out2), .c_valid(c_valid2), .c_ready(1'b1),
    .res_ovf(res_ovf2), .sat_flag(sat_flag2)
  );

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic term(input logic [7:0] a, input logic [7:0] b, input logic lst, input logic sgn);
    en_in = 1'b1; a_in = a; b_in = b; last_in = lst; signed_mode = sgn;
    tick();
  endtask

  task automatic idle(input int n);
    en_in = 1'b0; last_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: each negedge with c_valid & c_ready is exactly one accepted result.
  initial begin
    logic [31:0] req;
    forever begin
      @(negedge clk);
      if (!rst && c_valid && c_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_unexpected: got c_out=%0d, required no result", c_out);
        end else begin
          req = exp_q.pop_front();
          chkv("scoreboard_c_out", 32'(c_out), req);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MAC_SAT_EN
    exp_ovf = 32'h1FFFF; exp_sat = 1'b1;
`else
    exp_ovf = 32'd64003; exp_sat = 1'b0;
`endif
    rst = 1'b1; clr = 1'b0; en_in = 1'b0; signed_mode = 1'b0; last_in = 1'b0;
    a_in = '0; b_in = '0; c_ready = 1'b1;
    en2 = 1'b0; last2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    chk1("rst_en_out", en_out, 1'b0);
    chkv("rst_b_out", 32'(b_out), 32'd0);
    chk1("rst_last_out", last_out, 1'b0);
    chkv("rst_c_out", 32'(c_out), 32'd0);
    chk1("rst_c_valid", c_valid, 1'b0);
    chk1("rst_res_ovf", res_ovf, 1'b0);
    chk1("rst_sat_flag", sat_flag, 1'b0);
    rst = 1'b0;
    tick();

    // Unsigned dot product with latency/pulse checks.
    term(8'd3, 8'd4, 1'b0, 1'b0);
    term(8'd5, 8'd6, 1'b0, 1'b0);
    term(8'd255, 8'd255, 1'b0, 1'b0);
    exp_q.push_back(32'd65068);
    term(8'd1, 8'd1, 1'b1, 1'b0);
    idle(1);
    chk1("lat_edge_n1_c_valid", c_valid, 1'b0);
    tick();
    chk1("lat_edge_n2_c_valid", c_valid, 1'b1);
    tick();
    chk1("pulse_edge_n3_c_valid", c_valid, 1'b0);
    idle(2);

    // Signed dot product.
    term(8'hFE, 8'h03, 1'b0, 1'b1);
    exp_q.push_back(32'd16378);
    term(8'h80, 8'h80, 1'b1, 1'b1);
    idle(4);

    // Forward path: en 1,0,1, last held high so last_out = last_in & en_in.
    exp_q.push_back(32'd17);
    term(8'd1, 8'h11, 1'b1, 1'b0);
    chk1("fwd0_en_out", en_out, 1'b1);
    chkv("fwd0_b_out", 32'(b_out), 32'h11);
    chk1("fwd0_last_out", last_out, 1'b1);
    en_in = 1'b0; b_in = 8'h22; last_in = 1'b1;
    tick();
    chk1("fwd1_en_out", en_out, 1'b0);
    chkv("fwd1_b_out", 32'(b_out), 32'h22);
    chk1("fwd1_last_out", last_out, 1'b0);
    exp_q.push_back(32'd51);
    term(8'd1, 8'h33, 1'b1, 1'b0);
    chk1("fwd2_en_out", en_out, 1'b1);
    chkv("fwd2_b_out", 32'(b_out), 32'h33);
    chk1("fwd2_last_out", last_out, 1'b1);
    idle(4);

    // Backpressure: second result dropped.
    c_ready = 1'b0;
    exp_q.push_back(32'd6);
    term(8'd2, 8'd3, 1'b1, 1'b0);
    term(8'd4, 8'd5, 1'b1, 1'b0);
    idle(2);
    chkv("bp_c_out_held", 32'(c_out), 32'd6);
    chk1("bp_c_valid_held", c_valid, 1'b1);
    chk1("bp_res_ovf", res_ovf, 1'b1);
    c_ready = 1'b1;
    tick();
    chk1("bp_c_valid_drop", c_valid, 1'b0);

    // Completion coincident with handshake.
    c_ready = 1'b0;
    exp_q.push_back(32'd81);
    term(8'd9, 8'd9, 1'b1, 1'b0);
    idle(2);
    chk1("coinc_first_valid", c_valid, 1'b1);
    exp_q.push_back(32'd100);
    term(8'd10, 8'd10, 1'b1, 1'b0);
    idle(1);
    c_ready = 1'b1;
    tick();
    chk1("coinc_c_valid_stays", c_valid, 1'b1);
    chkv("coinc_c_out_new", 32'(c_out), 32'd100);
    tick();
    chk1("coinc_c_valid_drain", c_valid, 1'b0);
    idle(1);

    // clr mid-stream, with a competing term that must be ignored.
    term(8'd10, 8'd10, 1'b0, 1'b0);
    term(8'd20, 8'd20, 1'b0, 1'b0);
    clr = 1'b1;
    term(8'd3, 8'd3, 1'b1, 1'b0);
    clr = 1'b0;
    chk1("clr_en_out", en_out, 1'b0);
    chk1("clr_res_ovf", res_ovf, 1'b0);
    chk1("clr_c_valid", c_valid, 1'b0);
    exp_q.push_back(32'd56);
    term(8'd7, 8'd8, 1'b1, 1'b0);
    idle(5);

    // 17-bit accumulator overflow.
    for (int i = 0; i < 3; i++) begin
      en2 = 1'b1; a2 = 8'd255; b2 = 8'd255; last2 = (i == 2);
      tick();
    end
    en2 = 1'b0; last2 = 1'b0;
    tick();
    tick();
    chk1("ovf_c_valid", c_valid2, 1'b1);
    chkv("ovf_c_out", 32'(c_out2), exp_ovf);
    chk1("ovf_sat_flag", sat_flag2, exp_sat);
    tick();

    // Async reset mid-accumulation with a result pending.
    c_ready = 1'b0;
    term(8'd5, 8'd5, 1'b1, 1'b0);
    term(8'd6, 8'd6, 1'b0, 1'b0);
    term(8'd0, 8'h7F, 1'b0, 1'b0);
    chk1("prerst_c_valid", c_valid, 1'b1);
    chkv("prerst_b_out", 32'(b_out), 32'h7F);
    #2;
    rst = 1'b1; en_in = 1'b0; b_in = '0;
    #1;
    chk1("arst_en_out", en_out, 1'b0);
    chkv("arst_b_out", 32'(b_out), 32'd0);
    chkv("arst_c_out", 32'(c_out), 32'd0);
    chk1("arst_c_valid", c_valid, 1'b0);
    chk1("arst_sat_flag_ovf", sat_flag2, 1'b0);
    #1;
    rst = 1'b0;
    c_ready = 1'b1;
    tick();
    exp_q.push_back(32'd4);
    term(8'd2, 8'd2, 1'b1, 1'b0);
    idle(5);

    chkv("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk1("final_sat_flag", sat_flag, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_pe_pipe.md
Name: mac_pe_pipe

Overview:
Parametrised next-generation systolic MAC processing element for the matrix-multiply array.
- Two-stage pipeline: registered multiply, then accumulate.
- Selectable signed/unsigned operands and a configurable accumulator width.
- Dot products are delimited per stream with `last_in`; each completed sum goes to a result register with a valid/ready handshake, so the next dot product accumulates while the previous result drains.
- Forwards enable, B operand and `last` to the next PE with one-cycle delay.

Parameters:
- DATA_WIDTH, 8, width of `a_in`/`b_in`.
- ACC_WIDTH, 24, accumulator/result width; must be >= 2*DATA_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of all state except `sat_flag` (priority over `en_in`).
- en_in  in  1  operand pair valid this cycle.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `en_in`.
- a_in  in  DATA_WIDTH  A operand from FIFO.
- b_in  in  DATA_WIDTH  B operand from previous PE/FIFO.
- last_in  in  1  qualifies final term of current dot product (meaningful only with `en_in`).
- en_out  out  1  registered `en_in`.
- b_out  out  DATA_WIDTH  registered `b_in`.
- last_out  out  1  registered `last_in & en_in`.
- c_out  out  ACC_WIDTH  completed dot-product result.
- c_valid  out  1  `c_out` holds an unconsumed result.
- c_ready  in  1  consumer accepts result when `c_valid & c_ready`.
- res_ovf  out  1  sticky: a completed result was dropped.
- sat_flag  out  1  sticky: saturation occurred (see Optional Feature).

Behaviour:
- **Reset** (`rst` high, async): every register and output is 0 — `en_out`, `b_out`, `last_out`, `c_out`, `c_valid`, `res_ovf`, `sat_flag`, pipeline valid bits, accumulator.
- **Forward path:** `en_out`, `b_out` and `last_out` update every cycle (not gated by `en_in`). Latency is 1 cycle. `clr` forces them to 0.
- **Stage 1 (multiply):**
  - When `en_in`: `p_q` <= `a_in*b_in` (2*DATA_WIDTH bits, signed or unsigned per `signed_mode`).
  - `p_vld` <= 1, `p_last` <= `last_in`, `p_sgn` <= `signed_mode`.
  - Otherwise `p_vld` <= 0.
- **Stage 2 (accumulate):** on `p_vld`:
  - Extend `p_q` to ACC_WIDTH: sign-extend if `p_sgn`, else zero-extend.
  - `sum` = `base` + `ext(p_q)`, where `base` = 0 if `first` is set, else `acc`.
  - If `p_last`: result = `sum`, `acc` <= 0, `first` <= 1.
  - Otherwise: `acc` <= `sum`, `first` <= 0.
  - When `p_vld` is 0, `acc` holds its value.
  - Arithmetic wraps modulo 2^ACC_WIDTH unless `MAC_SAT_EN`.
- **Latency:** term with `last_in` at edge N -> `c_valid` = 1 and `c_out` = sum after edge N+2.
- **Result register:**
  - Loads on completion if `c_valid` = 0, or if `c_valid & c_ready` in the same cycle.
  - `c_valid` clears on handshake when no completion occurs in that cycle.
  - Completion while `c_valid = 1 & c_ready = 0`: the new result is dropped, `c_out` is unchanged, `res_ovf` <= 1.
- **`clr`:**
  - Zeroes `acc`, pipeline valids, forward outputs, `c_valid`, `c_out` and `res_ovf`.
  - Sets `first` <= 1; an in-flight product is discarded.
  - `sat_flag` is cleared only by `rst`.
- **Mode switching:** `signed_mode` may change between terms; each product uses its own sampled mode.
- **Single-term dot product:** `last_in` on the first term yields the product alone.
- **`rst` mid-accumulation:** partial sum lost; next term starts a fresh dot product.

Optional Feature:
- **Macro `MAC_SAT_EN`.**
- **Defined:** stage-2 addition saturates and `sat_flag` is set sticky on any clamp.
  - Signed term (`p_sgn` = 1): clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned term: clamps to [0, 2^ACC_WIDTH-1].
- **Undefined:** wrap-around arithmetic; `sat_flag` tied 0; no saturation logic synthesised.

Test Plan:
- **Unsigned dot product:** `signed_mode` = 0, pairs (3,4), (5,6), (255,255), (1,1) with `last_in` on the 4th, `c_ready` = 1 -> `c_out` = 65068 (0x00FE2C), `c_valid` pulses 1 cycle, 2 cycles after the 4th term.
- **Signed dot product:** `signed_mode` = 1, pairs (0xFE,0x03), (0x80,0x80), `last` on 2nd -> `c_out` = 16378 (0x003FFA).
- **Forward path:** `en_in` pattern 1,0,1 with `b_in` 0x11,0x22,0x33 -> `en_out`/`b_out` reproduce the pattern 1 cycle later; `last_out` follows `last_in & en_in`.
- **Backpressure:**
  - Two back-to-back single-term products 2*3 then 4*5 with `c_ready` = 0 -> `c_out` stays 6 and `res_ovf` = 1.
  - Raise `c_ready` -> `c_valid` drops the next cycle.
  - Completion coincident with handshake -> new result loads, `c_valid` stays 1.
- **Overflow arithmetic:** ACC_WIDTH = 17, unsigned, three terms 255*255 with `last` on 3rd -> with `MAC_SAT_EN`: `c_out` = 131071 (0x1FFFF), `sat_flag` = 1; without: `c_out` = 64003, `sat_flag` = 0.
- **`clr` mid-stream:** after 2 of 4 terms assert `clr`, then send (7,8) with `last` -> `c_out` = 56; `rst` pulse asynchronously zeroes all outputs within the same cycle.
